// File: rtl/opc_uart_pkg.sv
// Shared types and elaboration-time helpers for the opc5 UART receive path.
package opc_uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        BRK,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int uart_div(input int clkspeed, input int baud);
        return (clkspeed + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU-side receive interface: FIFO pop handshake and sticky error flags.
interface uart_rx_fifo_if;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       fifo_full;
    logic       overrun;
    logic       framing_err;

    modport master (
        output rd_en, err_clr,
        input  rd_data, rd_valid, fifo_full, overrun, framing_err
    );

    modport slave (
        input  rd_en, err_clr,
        output rd_data, rd_valid, fifo_full, overrun, framing_err
    );
endinterface

// File: rtl/uart_rx_sync_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO without a pop is dropped.
module uart_rx_sync_fifo #(
    parameter int FIFO_LOG2 = 4,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic [FIFO_LOG2:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 drop
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]   CNT_ONE  = (FIFO_LOG2+1)'(1);
    localparam logic [FIFO_LOG2:0]   CNT_FULL = (FIFO_LOG2+1)'(DEPTH);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [FIFO_LOG2-1:0] wptr;
    logic [FIFO_LOG2-1:0] rptr;
    logic                 do_push;
    logic                 do_pop;
    logic [FIFO_LOG2:0]   count_nxt;

    // Accept/drop decisions and next occupancy; a pop frees the slot a same-cycle push uses.
    always_comb begin
        do_pop    = pop & (count != '0);
        do_push   = push & ((count != CNT_FULL) | do_pop);
        drop      = push & (count == CNT_FULL) & ~do_pop;
        count_nxt = count;
        if (do_push & ~do_pop)
            count_nxt = count + CNT_ONE;
        else if (do_pop & ~do_push)
            count_nxt = count - CNT_ONE;
    end

    // Storage write; contents need no reset since head is qualified by count.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= push_data;
    end

    // Pointers, occupancy and the registered status flags derived from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push)
                wptr <= wptr + PTR_ONE;
            if (do_pop)
                rptr <= rptr + PTR_ONE;
            count <= count_nxt;
            full  <= (count_nxt == CNT_FULL);
            empty <= (count_nxt == '0);
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with 16x oversampling feeding a byte FIFO for the CPU.
//
// state | meaning
// BRK   | line low (reset or framing error); wait for it to go high
// IDLE  | line high; a low level starts a frame and rephases the prescaler
// START | count to mid start bit; high there means a glitch
// DATA  | sample 8 data bits LSB first, one per 16 ticks
// STOP  | sample stop bit; high pushes the byte, low flags framing error
module uart_rx_fifo
    import opc_uart_pkg::*;
#(
    parameter int CLKSPEED  = 40000000,
    parameter int BAUD      = 115200,
    parameter int FIFO_LOG2 = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rxd,
    uart_rx_fifo_if.slave   cpu
);
    localparam int DIV = uart_div(CLKSPEED, BAUD);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);
    localparam logic [3:0]    T_MID    = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    T_LAST   = 4'(OVERSAMPLE - 1);

    rx_state_t            state;
    logic                 rx_meta;
    logic                 rxs;
    logic [PW-1:0]        pre;
    logic                 tick;
    logic                 pre_load;
    logic [3:0]           tcnt;
    logic [2:0]           bitidx;
    logic [7:0]           shift;
    logic                 stop_sample;
    logic                 push;
    logic                 ferr_set;
    logic                 drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_head;
    logic [FIFO_LOG2:0]   fifo_count;
    logic                 overrun_q;
    logic                 framing_q;

    // Two-flop synchroniser for the asynchronous line.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b0;
            rxs     <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    assign pre_load = (state == IDLE) & ~rxs;
    assign tick     = (pre == PRE_LAST);

    // Oversample prescaler, restarted on the start edge so samples land mid-bit.
    always_ff @(posedge clk) begin
        if (reset || pre_load || tick)
            pre <= '0;
        else
            pre <= pre + PRE_ONE;
    end

    // Receive FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= BRK;
            tcnt   <= '0;
            bitidx <= '0;
            shift  <= '0;
        end else begin
            case (state)
                BRK: begin
                    if (rxs)
                        state <= IDLE;
                end
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        tcnt  <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tcnt == T_MID) begin
                            tcnt   <= '0;
                            bitidx <= '0;
                            state  <= rxs ? IDLE : DATA;
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == T_LAST) begin
                            shift[bitidx] <= rxs;
                            if (bitidx == 3'd7)
                                state <= STOP;
                            else
                                bitidx <= bitidx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == T_LAST)
                            state <= rxs ? IDLE : BRK;
                    end
                end
                default: state <= BRK;
            endcase
        end
    end

    // The push must land in the stop-sample cycle itself, so it is decoded, not registered.
    assign stop_sample = (state == STOP) & tick & (tcnt == T_LAST);
    assign push        = stop_sample & rxs;
    assign ferr_set    = stop_sample & ~rxs;

    uart_rx_sync_fifo #(
        .FIFO_LOG2 (FIFO_LOG2),
        .WIDTH     (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift),
        .pop       (cpu.rd_en & cpu.rd_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (drop)
    );

    // Sticky error flags; a set in the same cycle as a clear keeps the flag high.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
        end else begin
            if (drop)
                overrun_q <= 1'b1;
            else if (cpu.err_clr)
                overrun_q <= 1'b0;
            if (ferr_set)
                framing_q <= 1'b1;
            else if (cpu.err_clr)
                framing_q <= 1'b0;
        end
    end

    assign cpu.rd_data     = (fifo_count != '0) ? fifo_head : 8'h00;
    assign cpu.rd_valid    = ~fifo_empty;
    assign cpu.fifo_full   = fifo_full;
    assign cpu.overrun     = overrun_q;
    assign cpu.framing_err = framing_q;

endmodule
